// File: rtl/handshake_sender_controller_pkg.sv
// Shared types and default constants for the 4-phase handshake sender.
package handshake_sender_controller_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQUEST = 2'd1,
      RELEASE = 2'd2
   } handshake_state_t;

   localparam int DEFAULT_STAGES         = 2;
   localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/handshake_acknowledge_synchronizer.sv
// Multi-flop synchronizer bringing the foreign acknowledge into the sending clock domain.
module handshake_acknowledge_synchronizer
   import handshake_sender_controller_pkg::*;
#(
   parameter int STAGES = DEFAULT_STAGES
) (
   input  logic clock,
   input  logic reset,
   input  logic data_in,
   output logic data_out
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= data_in;
         for (int i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign data_out = sync_q[STAGES-1];

endmodule

// File: rtl/handshake_sender_controller.sv
// Source-side 4-phase req/ack controller; holds the accepted word on request_data while busy.
// Optional HANDSHAKE_SENDER_CONTROLLER_TIMEOUT_EN adds a sticky per-phase timeout flag.
//
// state   | meaning
// IDLE    | waiting for a word; ready only once ack_sync is low
// REQUEST | request high, waiting for ack_sync to rise
// RELEASE | request low, waiting for ack_sync to fall
module handshake_sender_controller
   import handshake_sender_controller_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int STAGES         = DEFAULT_STAGES,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] write_data,
   input  logic             write_valid,
   output logic             write_ready,
   output logic             write_done,
   output logic             busy,
   output logic             request,
   output logic [WIDTH-1:0] request_data,
   input  logic             acknowledge
`ifdef HANDSHAKE_SENDER_CONTROLLER_TIMEOUT_EN
   ,
   output logic             timeout_error
`endif
);

   handshake_state_t state, next_state;
   logic             ack_sync;
   logic             accept;

   handshake_acknowledge_synchronizer #(
      .STAGES (STAGES)
   ) u_ack_sync (
      .clock    (clock),
      .reset    (reset),
      .data_in  (acknowledge),
      .data_out (ack_sync)
   );

   // request and write_done are flops so nothing combinational crosses to the receiver
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         request      <= 1'b0;
         request_data <= '0;
         write_done   <= 1'b0;
      end else begin
         state      <= next_state;
         request    <= (next_state == REQUEST);
         write_done <= (state == RELEASE) && (next_state == IDLE);
         if (accept) begin
            request_data <= write_data;
         end
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept)    next_state = REQUEST;
         REQUEST: if (ack_sync)  next_state = RELEASE;
         RELEASE: if (!ack_sync) next_state = IDLE;
         default:                next_state = IDLE;
      endcase
   end

   always_comb begin
      write_ready = (state == IDLE) && !ack_sync;
      busy        = (state != IDLE);
      accept      = write_valid && write_ready;
   end

`ifdef HANDSHAKE_SENDER_CONTROLLER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] phase_count;

   // counter saturates; the flag is raised on the increment that reaches TIMEOUT_CYCLES
   always_ff @(posedge clock) begin
      if (reset) begin
         phase_count   <= '0;
         timeout_error <= 1'b0;
      end else if (next_state != state) begin
         phase_count <= '0;
      end else if (busy && (phase_count != CW'(TIMEOUT_CYCLES))) begin
         phase_count <= phase_count + CW'(1);
         if (phase_count == CW'(TIMEOUT_CYCLES - 1)) begin
            timeout_error <= 1'b1;
         end
      end
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

endmodule
